// File: rtl/knn_pkg.sv
// -----------------------------------------------------------------------------
// knn_pkg
// Shared definitions for the KNN distance path.
//   - FSM state encodings for the squared-distance producer.
//   - acc_width(): result width of the squared-distance accumulator. The sqrt
//     instantiation calls the same function so its WIDTH always matches.
// -----------------------------------------------------------------------------
package knn_pkg;

   // Producer FSM states (plain constants so legacy code can share them)
   localparam logic [1:0] S_WAIT = 2'd0;  // ready for the next element pair
   localparam logic [1:0] S_MUL  = 2'd1;  // shift-add squaring in progress
   localparam logic [1:0] S_DONE = 2'd2;  // distance presented downstream

   // Sum of dim squares of elem_width-bit values needs
   // 2*elem_width + clog2(dim) bits.
   function automatic int acc_width(input int elem_width, input int dim);
      return 2 * elem_width + $clog2(dim);
   endfunction

endpackage

// File: rtl/sq_iter.sv
// -----------------------------------------------------------------------------
// sq_iter
// Iterative shift-add squarer. One operand bit is examined per clock, so a
// square takes exactly ELEM_WIDTH cycles after start_i.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset, abandons any square in progress
//   start_i  load d_i and begin squaring (ignored handling while busy is the
//            caller's job; the caller only starts when idle)
//   d_i      operand (the absolute difference), ELEM_WIDTH bits
//   done_o   single-cycle pulse on the last iteration
//   prod_o   d*d, valid in the cycle done_o is high
// -----------------------------------------------------------------------------
module sq_iter #(
   parameter int ELEM_WIDTH = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic                      start_i,
   input  logic [ELEM_WIDTH-1:0]     d_i,
   output logic                      done_o,
   output logic [2*ELEM_WIDTH-1:0]   prod_o
);

   localparam int JW = (ELEM_WIDTH > 1) ? $clog2(ELEM_WIDTH) : 1;

   logic [ELEM_WIDTH-1:0]   r_d;
   logic [2*ELEM_WIDTH-1:0] r_p;
   logic [JW-1:0]           r_j;
   logic                    r_busy;
   logic [2*ELEM_WIDTH-1:0] w_p_next;

   // Partial product including the current bit; exported directly so the
   // accumulator can add the finished square on the last iteration without
   // waiting an extra cycle.
   always_comb begin
      // NOTE: assign a default before any condition so no latch is inferred.
      w_p_next = r_p;
      if (r_d[r_j])
         w_p_next = r_p + ({{ELEM_WIDTH{1'b0}}, r_d} << r_j);
   end

   assign done_o = r_busy && (r_j == JW'(ELEM_WIDTH - 1));
   assign prod_o = w_p_next;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         // NOTE: state updates use non-blocking assignments so every register
         // samples the pre-edge values regardless of statement order.
         r_d    <= '0;
         r_p    <= '0;
         r_j    <= '0;
         r_busy <= 1'b0;
      end else if (start_i) begin
         r_d    <= d_i;
         r_p    <= '0;
         r_j    <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_p <= w_p_next;
         r_j <= r_j + JW'(1);
         if (done_o)
            r_busy <= 1'b0;
      end
   end

endmodule

// File: rtl/sq_dist_accum.sv
// -----------------------------------------------------------------------------
// sq_dist_accum
// Streams DIM unsigned element pairs, squares each |a-b| with sq_iter and
// accumulates the squared Euclidean distance, then offers it on a valid/ready
// output that plugs straight into the sqrt unit.
// Ports:
//   clk_i    clock
//   rst_i    synchronous active-high reset; discards partial work
//   valid_i  element pair present on a_i/b_i
//   ready_o  pair accepted this cycle if valid_i (high only in S_WAIT)
//   a_i      query element, unsigned
//   b_i      reference element, unsigned
//   valid_o  dist_o holds a completed distance (S_DONE)
//   ready_i  downstream accepts dist_o
//   dist_o   accumulator; meaningful only while valid_o is high
// -----------------------------------------------------------------------------
module sq_dist_accum
   import knn_pkg::*;
#(
   parameter  int ELEM_WIDTH = 8,
   parameter  int DIM        = 4,
   localparam int ACC_WIDTH  = acc_width(ELEM_WIDTH, DIM)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  logic [ELEM_WIDTH-1:0] a_i,
   input  logic [ELEM_WIDTH-1:0] b_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [ACC_WIDTH-1:0]  dist_o
);

   localparam int EW = $clog2(DIM);

   logic [1:0]              r_ps;
   logic [EW-1:0]           r_e;
   logic [ACC_WIDTH-1:0]    r_acc;

   logic                    w_accept;
   logic [ELEM_WIDTH:0]     w_diff;
   logic [ELEM_WIDTH-1:0]   w_abs;
   logic                    w_sq_done;
   logic [2*ELEM_WIDTH-1:0] w_sq;

   assign w_accept = (r_ps == S_WAIT) && valid_i;

   // |a-b| from a one-bit-wider subtract: the extra bit is the borrow, and a
   // borrow means the low bits hold b-a in two's complement, so negate them.
   always_comb begin
      w_diff = {1'b0, a_i} - {1'b0, b_i};
      w_abs  = w_diff[ELEM_WIDTH-1:0];
      if (w_diff[ELEM_WIDTH])
         w_abs = ~w_diff[ELEM_WIDTH-1:0] + ELEM_WIDTH'(1);
   end

   sq_iter #(
      .ELEM_WIDTH (ELEM_WIDTH)
   ) u_sq_iter (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start_i (w_accept),
      .d_i     (w_abs),
      .done_o  (w_sq_done),
      .prod_o  (w_sq)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ps  <= S_WAIT;
         r_e   <= '0;
         r_acc <= '0;
      end else begin
         case (r_ps)
            S_WAIT: begin
               if (valid_i)
                  r_ps <= S_MUL;
            end
            S_MUL: begin
               if (w_sq_done) begin
                  r_acc <= r_acc + ACC_WIDTH'(w_sq);
                  if (r_e == EW'(DIM - 1)) begin
                     r_e  <= '0;
                     r_ps <= S_DONE;
                  end else begin
                     r_e  <= r_e + EW'(1);
                     r_ps <= S_WAIT;
                  end
               end
            end
            S_DONE: begin
               // Clearing here (not on the next accept) keeps the output
               // stable for the whole hold and starts each vector at zero.
               if (ready_i) begin
                  r_acc <= '0;
                  r_ps  <= S_WAIT;
               end
            end
            default: r_ps <= S_WAIT;
         endcase
      end
   end

   assign ready_o = (r_ps == S_WAIT);
   assign valid_o = (r_ps == S_DONE);
   assign dist_o  = r_acc;

endmodule

// File: tb/tb_sq_dist_accum.sv
// -----------------------------------------------------------------------------
// tb_sq_dist_accum
// Self-checking bench for sq_dist_accum with default parameters. Expected
// distances come from plain integer arithmetic on the stimulus vectors.
// -----------------------------------------------------------------------------
module tb_sq_dist_accum;

   localparam int EW  = 8;
   localparam int DIM = 4;
   localparam int AW  = 2 * EW + $clog2(DIM);

   typedef logic [EW-1:0] vec_t [DIM];

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          valid_i;
   logic          ready_o;
   logic [EW-1:0] a_i;
   logic [EW-1:0] b_i;
   logic          valid_o;
   logic          ready_i;
   logic [AW-1:0] dist_o;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int acc_cyc [DIM];
   int v_cyc;

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   sq_dist_accum #(
      .ELEM_WIDTH (EW),
      .DIM        (DIM)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .valid_i (valid_i),
      .ready_o (ready_o),
      .a_i     (a_i),
      .b_i     (b_i),
      .valid_o (valid_o),
      .ready_i (ready_i),
      .dist_o  (dist_o)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: squared Euclidean distance with ordinary integers.
   function automatic int ref_dist(input vec_t va, input vec_t vb);
      int s = 0;
      for (int i = 0; i < DIM; i++) begin
         int d = int'(va[i]) - int'(vb[i]);
         s += d * d;
      end
      return s;
   endfunction

   // Offer the first n pairs of a vector, with 0..max_gap idle cycles of
   // random garbage (valid_i low) before each one. Returns at the negedge
   // following the last accept, with valid_i low.
   task automatic send_vec(input vec_t va, input vec_t vb, input int max_gap, input int n);
      for (int e = 0; e < n; e++) begin
         int gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
         int t   = 0;
         repeat (gap) begin
            valid_i = 1'b0;
            a_i     = EW'($urandom);
            b_i     = EW'($urandom);
            @(negedge clk_i);
         end
         valid_i = 1'b1;
         a_i     = va[e];
         b_i     = vb[e];
         while (!ready_o && t < 100) begin
            @(negedge clk_i);
            t++;
         end
         if (t >= 100) check("accept_timeout", 0, 1);
         acc_cyc[e] = cyc;
         @(negedge clk_i);
      end
      valid_i = 1'b0;
   endtask

   task automatic wait_valid();
      int t = 0;
      while (!valid_o && t < 200) begin
         @(negedge clk_i);
         t++;
      end
      if (t >= 200) check("valid_timeout", 0, 1);
      v_cyc = cyc;
   endtask

   // Called at the negedge valid_o is first seen. Holds ready_i low for
   // 'hold' cycles (optionally offering new data meanwhile), then transfers.
   task automatic finish_vec(input string tag, input int exp, input int hold, input bit noise);
      check({tag, "_dist"}, dist_o, exp);
      ready_i = (hold == 0);
      for (int h = 0; h < hold; h++) begin
         if (noise) begin
            valid_i = 1'b1;
            a_i     = EW'($urandom);
            b_i     = EW'($urandom);
         end
         @(negedge clk_i);
         check({tag, "_hold_valid"}, valid_o, 1);
         check({tag, "_hold_ready"}, ready_o, 0);
         check({tag, "_hold_dist"}, dist_o, exp);
      end
      ready_i = 1'b1;
      @(negedge clk_i);
      valid_i = 1'b0;
      check({tag, "_post_valid"}, valid_o, 0);
      check({tag, "_post_ready"}, ready_o, 1);
      check({tag, "_post_clear"}, dist_o, 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t va;
      vec_t vb;
      rst_i   = 1'b1;
      valid_i = 1'b0;
      ready_i = 1'b1;
      a_i     = '0;
      b_i     = '0;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;

      // Reset state, then idle (ready_i high before any result: no effect).
      check("rst_ready", ready_o, 1);
      check("rst_valid", valid_o, 0);
      check("rst_dist", dist_o, 0);
      repeat (3) @(negedge clk_i);
      check("idle_ready", ready_o, 1);
      check("idle_valid", valid_o, 0);

      // Directed vector, back-to-back: latency and element spacing.
      va = '{8'd3, 8'd10, 8'd0, 8'd255};
      vb = '{8'd7, 8'd4, 8'd0, 8'd0};
      send_vec(va, vb, 0, DIM);
      wait_valid();
      check("lat_first_to_valid", v_cyc - acc_cyc[0], DIM * (EW + 1));
      for (int e = 1; e < DIM; e++)
         check("ready_spacing", acc_cyc[e] - acc_cyc[e-1], EW + 1);
      finish_vec("dir", ref_dist(va, vb), 0, 0);
      check("dir_const", ref_dist(va, vb), 65077);

      // Maximum sum, no wrap.
      va = '{8'd255, 8'd255, 8'd255, 8'd255};
      vb = '{8'd0, 8'd0, 8'd0, 8'd0};
      send_vec(va, vb, 0, DIM);
      wait_valid();
      check("max_dist_abs", dist_o, 260100);
      finish_vec("max", ref_dist(va, vb), 0, 0);

      // Equal vectors give zero; also b > a direction.
      va = '{8'd200, 8'd200, 8'd200, 8'd200};
      send_vec(va, va, 1, DIM);
      wait_valid();
      finish_vec("zero", 0, 0, 0);
      send_vec(vb, '{8'd255, 8'd1, 8'd128, 8'd7}, 1, DIM);
      wait_valid();
      finish_vec("neg", 65025 + 1 + 16384 + 49, 0, 0);

      // Backpressure with new data offered during the hold.
      for (int i = 0; i < DIM; i++) begin
         va[i] = EW'($urandom);
         vb[i] = EW'($urandom);
      end
      send_vec(va, vb, 0, DIM);
      wait_valid();
      finish_vec("bp", ref_dist(va, vb), 5, 1);

      // Input gaps; two consecutive vectors must be independent.
      va = '{8'd1, 8'd2, 8'd3, 8'd4};
      vb = '{8'd4, 8'd3, 8'd2, 8'd1};
      for (int k = 0; k < 2; k++) begin
         send_vec(va, vb, 3, DIM);
         wait_valid();
         finish_vec("gap", 20, 0, 0);
      end

      // Reset held 3 cycles in the middle of the third element's squaring.
      va = '{8'd100, 8'd9, 8'd250, 8'd17};
      vb = '{8'd3, 8'd90, 8'd5, 8'd170};
      send_vec(va, vb, 0, 3);
      repeat (3) @(negedge clk_i);
      rst_i = 1'b1;
      repeat (3) @(negedge clk_i);
      rst_i = 1'b0;
      check("mid_rst_ready", ready_o, 1);
      check("mid_rst_valid", valid_o, 0);
      check("mid_rst_dist", dist_o, 0);
      send_vec(va, vb, 2, DIM);
      wait_valid();
      finish_vec("after_rst", ref_dist(va, vb), 0, 0);

      // Randomized vectors, gaps and backpressure.
      for (int k = 0; k < 10; k++) begin
         for (int i = 0; i < DIM; i++) begin
            va[i] = EW'($urandom);
            vb[i] = EW'($urandom);
         end
         send_vec(va, vb, 3, DIM);
         wait_valid();
         finish_vec("rand", ref_dist(va, vb), int'($urandom_range(3, 0)), 1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
